// File: rtl/timer_bank_if.sv
// rtl/timer_bank_if.sv - register access port of the timer bank
interface timer_bank_if #(
    parameter int CNT_WIDTH = 16
);
    logic                 we;
    logic [2:0]           ch_sel;
    logic [1:0]           reg_sel;
    logic [CNT_WIDTH-1:0] wdata;
    logic [CNT_WIDTH-1:0] rdata;

    modport master (
        output we,
        output ch_sel,
        output reg_sel,
        output wdata,
        input  rdata
    );

    modport slave (
        input  we,
        input  ch_sel,
        input  reg_sel,
        input  wdata,
        output rdata
    );
endinterface

// File: rtl/timer_bank.sv
// rtl/timer_bank.sv - multi-channel programmable interrupt timer
module timer_bank #(
    parameter int NUM_CH    = 4,
    parameter int CNT_WIDTH = 16,
    parameter int IRQ_WIDTH = 8,
    parameter int IRQ_BASE  = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    timer_bank_if.slave          bus,
    output logic [IRQ_WIDTH-1:0] interruptions
);

    localparam logic [1:0] REG_PERIOD = 2'd0;
    localparam logic [1:0] REG_CTRL   = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    logic [CNT_WIDTH-1:0] period [NUM_CH];
    logic [CNT_WIDTH-1:0] count  [NUM_CH];
    logic [NUM_CH-1:0]    en;
    logic [NUM_CH-1:0]    oneshot;
    logic [NUM_CH-1:0]    irq_en;
    logic [NUM_CH-1:0]    pending;

    logic [NUM_CH-1:0]    hit;
    logic [NUM_CH-1:0]    wr_period;
    logic [NUM_CH-1:0]    wr_ctrl;
    logic [NUM_CH-1:0]    wr_status;
    logic [NUM_CH-1:0]    running;
    logic [NUM_CH-1:0]    expire;
    logic [NUM_CH-1:0]    start;
    logic [CNT_WIDTH-1:0] rd;

    // Per-channel write decode and count/expire qualifiers; out-of-range ch_sel matches nothing
    always_comb begin
        hit       = '0;
        wr_period = '0;
        wr_ctrl   = '0;
        wr_status = '0;
        running   = '0;
        expire    = '0;
        start     = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            hit[i]       = bus.we && (bus.ch_sel == 3'(i));
            wr_period[i] = hit[i] && (bus.reg_sel == REG_PERIOD);
            wr_ctrl[i]   = hit[i] && (bus.reg_sel == REG_CTRL);
            wr_status[i] = hit[i] && (bus.reg_sel == REG_STATUS);
            running[i]   = en[i] && (period[i] != '0);
            expire[i]    = running[i] && (count[i] == CNT_WIDTH'(1));
            start[i]     = wr_ctrl[i] && bus.wdata[0] && !en[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                period[i] <= '0;
                count[i]  <= '0;
            end
            en      <= '0;
            oneshot <= '0;
            irq_en  <= '0;
            pending <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (wr_period[i]) begin
                    period[i] <= bus.wdata;
                end

                // Expiry needs en=1, so it never coincides with an enable-load
                if (expire[i]) begin
                    count[i] <= oneshot[i] ? '0 : period[i];
                end else if (start[i]) begin
                    count[i] <= period[i];
                end else if (running[i] && (count[i] > CNT_WIDTH'(1))) begin
                    count[i] <= count[i] - CNT_WIDTH'(1);
                end

                if (wr_ctrl[i]) begin
                    en[i]      <= bus.wdata[0];
                    oneshot[i] <= bus.wdata[1];
                    irq_en[i]  <= bus.wdata[2];
                end else if (expire[i] && oneshot[i]) begin
                    en[i] <= 1'b0;
                end

                // A same-edge expiry beats a software clear
                if (expire[i]) begin
                    pending[i] <= 1'b1;
                end else if (wr_status[i] && bus.wdata[0]) begin
                    pending[i] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        rd = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (bus.ch_sel == 3'(i)) begin
                case (bus.reg_sel)
                    REG_PERIOD: rd = period[i];
                    REG_CTRL:   rd = CNT_WIDTH'({irq_en[i], oneshot[i], en[i]});
                    REG_COUNT:  rd = count[i];
                    default:    rd = CNT_WIDTH'({en[i], pending[i]});
                endcase
            end
        end
    end

    assign bus.rdata = rd;

    always_comb begin
        interruptions = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            interruptions[IRQ_BASE + i] = pending[i] & irq_en[i];
        end
    end

endmodule

// File: tb/tb_timer_bank.sv
// tb/tb_timer_bank.sv - self-checking bench for timer_bank
module tb_timer_bank;

    localparam int NCH   = 4;
    localparam int CW    = 16;
    localparam int IW    = 8;
    localparam int IBASE = 2;

    logic          clk;
    logic          reset;
    logic [IW-1:0] interruptions;

    timer_bank_if #(.CNT_WIDTH(CW)) bus ();

    timer_bank #(
        .NUM_CH   (NCH),
        .CNT_WIDTH(CW),
        .IRQ_WIDTH(IW),
        .IRQ_BASE (IBASE)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .interruptions(interruptions)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Time-based model: a running channel is described by the edge number at which it
    // next expires; a stopped channel by the value its counter froze at.
    int cyc = 0;
    int m_period [NCH];
    int m_due    [NCH];
    int m_hold   [NCH];
    bit m_en     [NCH];
    bit m_os     [NCH];
    bit m_ie     [NCH];
    bit m_pend   [NCH];
    bit m_run    [NCH];
    int t;
    bit en_old;
    bit ex;

    initial begin
        for (int i = 0; i < NCH; i++) begin
            m_period[i] = 0; m_due[i] = 0; m_hold[i] = 0;
            m_en[i] = 0; m_os[i] = 0; m_ie[i] = 0; m_pend[i] = 0; m_run[i] = 0;
        end
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            cyc = 0;
            for (int i = 0; i < NCH; i++) begin
                m_period[i] = 0; m_due[i] = 0; m_hold[i] = 0;
                m_en[i] = 0; m_os[i] = 0; m_ie[i] = 0; m_pend[i] = 0; m_run[i] = 0;
            end
        end else begin
            t = cyc + 1;
            for (int i = 0; i < NCH; i++) begin
                en_old = m_en[i];
                ex     = m_run[i] && (m_due[i] == t);
                if (ex) begin
                    m_pend[i] = 1'b1;
                    if (m_os[i]) begin
                        m_en[i] = 1'b0; m_run[i] = 1'b0; m_hold[i] = 0;
                    end else begin
                        m_due[i] = t + m_period[i];
                    end
                end
                if (bus.we && int'(bus.ch_sel) == i) begin
                    case (bus.reg_sel)
                        2'd0: m_period[i] = int'(bus.wdata);
                        2'd1: begin
                            if (bus.wdata[0] && !en_old) begin
                                if (m_period[i] != 0) begin
                                    m_run[i] = 1'b1; m_due[i] = t + m_period[i];
                                end else begin
                                    m_run[i] = 1'b0; m_hold[i] = 0;
                                end
                            end else if (!bus.wdata[0] && m_run[i]) begin
                                m_hold[i] = m_due[i] - t;
                                m_run[i]  = 1'b0;
                            end
                            m_en[i] = bus.wdata[0];
                            m_os[i] = bus.wdata[1];
                            m_ie[i] = bus.wdata[2];
                        end
                        2'd3: if (bus.wdata[0] && !ex) m_pend[i] = 1'b0;
                        default: ;
                    endcase
                end
            end
            cyc = t;
        end
    end

    function automatic int m_count(input int c);
        return m_run[c] ? (m_due[c] - cyc) : m_hold[c];
    endfunction

    function automatic logic [CW-1:0] m_rdata();
        int c;
        c = int'(bus.ch_sel);
        if (c >= NCH) return '0;
        case (bus.reg_sel)
            2'd0:    return CW'(m_period[c]);
            2'd1:    return CW'({m_ie[c], m_os[c], m_en[c]});
            2'd2:    return CW'(m_count(c));
            default: return CW'({m_en[c], m_pend[c]});
        endcase
    endfunction

    function automatic logic [IW-1:0] m_irq();
        logic [IW-1:0] v;
        v = '0;
        for (int i = 0; i < NCH; i++) v[IBASE + i] = m_pend[i] & m_ie[i];
        return v;
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            chk("model_rdata", 32'(bus.rdata), 32'(m_rdata()));
            chk("model_irq", 32'(interruptions), 32'(m_irq()));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input int ch, input int rg, input int d);
        bus.we      = 1'b1;
        bus.ch_sel  = 3'(ch);
        bus.reg_sel = 2'(rg);
        bus.wdata   = CW'(d);
        @(posedge clk);
        #1;
        bus.we = 1'b0;
    endtask

    task automatic rd(input string nm, input int ch, input int rg, input int exp);
        bus.ch_sel  = 3'(ch);
        bus.reg_sel = 2'(rg);
        #1;
        chk(nm, 32'(bus.rdata), 32'(exp));
    endtask

    initial begin
        reset       = 1'b1;
        bus.we      = 1'b0;
        bus.ch_sel  = '0;
        bus.reg_sel = '0;
        bus.wdata   = '0;
        step(2);
        reset = 1'b0;

        rd("rst_period", 0, 0, 0);
        rd("rst_ctrl", 0, 1, 0);
        rd("rst_count", 0, 2, 0);
        step(1);
        rd("rst_status", 3, 3, 0);
        chk("rst_irq", 32'(interruptions), 0);

        // Ch0 periodic, P=5
        wr(0, 0, 5);
        wr(0, 1, 5);
        rd("t1_count5", 0, 2, 5);
        for (int v = 4; v >= 1; v--) begin
            step(1);
            rd("t1_countdown", 0, 2, v);
        end
        chk("t1_irq_before", 32'(interruptions), 0);
        step(1);
        rd("t1_status", 0, 3, 3);
        rd("t1_reload", 0, 2, 5);
        chk("t1_irq_set", 32'(interruptions), 32'h04);
        wr(0, 3, 1);
        chk("t1_irq_clr", 32'(interruptions), 0);
        step(3);
        chk("t1_irq_k9", 32'(interruptions), 0);
        step(1);
        chk("t1_irq_k10", 32'(interruptions), 32'h04);
        wr(0, 3, 1);
        wr(0, 1, 0);
        rd("t1_hold", 0, 2, 3);
        rd("t1_ctrl_off", 0, 1, 0);
        step(3);
        rd("t1_hold_later", 0, 2, 3);
        rd("t1_status_off", 0, 3, 0);

        // Ch1 one-shot, P=3
        wr(1, 0, 3);
        wr(1, 1, 7);
        step(2);
        chk("t2_irq_before", 32'(interruptions), 0);
        step(1);
        chk("t2_irq_set", 32'(interruptions), 32'h08);
        rd("t2_ctrl", 1, 1, 6);
        rd("t2_count", 1, 2, 0);
        wr(1, 3, 1);
        step(20);
        rd("t2_no_reexpire", 1, 3, 0);
        chk("t2_irq_quiet", 32'(interruptions), 0);

        // Set beats clear on the same edge
        wr(0, 0, 2);
        wr(0, 1, 5);
        step(1);
        wr(0, 3, 1);
        rd("t3_status", 0, 3, 3);
        chk("t3_irq", 32'(interruptions), 32'h04);
        rd("t3_count", 0, 2, 2);
        wr(0, 1, 0);
        wr(0, 3, 1);
        chk("t3_irq_clr", 32'(interruptions), 0);

        // Mask and mapping
        wr(0, 0, 4);
        wr(0, 1, 1);
        wr(1, 0, 6);
        wr(1, 1, 5);
        step(2);
        rd("t4_ch0_pending", 0, 3, 3);
        chk("t4_masked", 32'(interruptions), 0);
        step(4);
        chk("t4_ch1_irq", 32'(interruptions), 32'h08);
        rd("t4_ch0_sticky", 0, 3, 3);
        wr(0, 1, 0);
        wr(1, 1, 0);
        wr(0, 3, 1);
        wr(1, 3, 1);
        chk("t4_irq_clr", 32'(interruptions), 0);

        // Period change mid-run and out-of-range channel
        wr(0, 0, 8);
        wr(0, 1, 5);
        step(3);
        rd("t5_count5", 0, 2, 5);
        wr(0, 0, 2);
        rd("t5_period", 0, 0, 2);
        rd("t5_count4", 0, 2, 4);
        step(3);
        chk("t5_irq_before", 32'(interruptions), 0);
        step(1);
        chk("t5_irq_first", 32'(interruptions), 32'h04);
        rd("t5_reload2", 0, 2, 2);
        wr(0, 3, 1);
        chk("t5_irq_clr", 32'(interruptions), 0);
        step(1);
        chk("t5_irq_second", 32'(interruptions), 32'h04);
        wr(6, 0, 16'h1234);
        wr(6, 1, 7);
        rd("t5_ch6_period", 6, 0, 0);
        rd("t5_ch6_ctrl", 6, 1, 0);
        rd("t5_ch0_period", 0, 0, 2);

        // Reset mid-operation
        wr(0, 1, 0);
        wr(0, 0, 8);
        wr(0, 1, 5);
        step(5);
        rd("t6_count3", 0, 2, 3);
        rd("t6_pending", 0, 3, 3);
        chk("t6_irq_pre", 32'(interruptions), 32'h04);
        reset = 1'b1;
        #1;
        chk("t6_irq_async", 32'(interruptions), 0);
        chk("t6_rdata_async", 32'(bus.rdata), 0);
        #9;
        reset = 1'b0;
        step(1);
        rd("t6_period", 0, 0, 0);
        rd("t6_ctrl", 0, 1, 0);
        rd("t6_count", 0, 2, 0);
        step(12);
        rd("t6_status", 0, 3, 0);
        chk("t6_irq_quiet", 32'(interruptions), 0);

        step(1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/timer_bank.md
Name: timer_bank

Overview:
Multi-channel programmable interrupt timer, the parametrised successor of the single fixed-period timer that drives the CPU's `interruptions` bus.
- Provides NUM_CH independent down-counters, each with a programmable period, a periodic or one-shot mode, a sticky pending flag and a per-channel interrupt mask.
- Sits beside i_o_manager: register-style write/read port from the I/O address decode, with its outputs mapped onto selected bits of the CPU interrupt vector.

Parameters:
NUM_CH, 4, number of timer channels (1..8)
CNT_WIDTH, 16, width of period/counter registers and data port
IRQ_WIDTH, 8, width of interruptions bus
IRQ_BASE, 0, bit index of channel 0 on interruptions; IRQ_BASE+NUM_CH <= IRQ_WIDTH

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all state
we  input  1  register write strobe, sampled on rising clk
ch_sel  input  3  channel select
reg_sel  input  2  0=PERIOD, 1=CTRL, 2=COUNT (read-only), 3=STATUS
wdata  input  CNT_WIDTH  write data
rdata  output  CNT_WIDTH  combinational read of selected register
interruptions  output  IRQ_WIDTH  interrupt lines to CPU

Behaviour:
- Reset: all PERIOD, CTRL, COUNT and pending registers are 0. interruptions=0. rdata=0.
- CTRL bits: [0] en, [1] oneshot (0=periodic), [2] irq_en. Other bits read 0.
- STATUS read: [0] pending, [1] en. STATUS write with wdata[0]=1 clears pending. wdata[0]=0 has no effect.
- Write to COUNT is ignored.
- ch_sel >= NUM_CH: writes ignored, rdata=0.
- Enable: a CTRL write setting en 0->1 at edge k loads COUNT=PERIOD after edge k.
  - Writing en=1 while already enabled does not reload.
  - Writing en=0 stops the counter; COUNT holds its value.
- Counting, evaluated each edge while en=1 and PERIOD!=0:
  - If COUNT>1: COUNT decrements.
  - If COUNT==1: expire event. pending<=1.
    - Periodic: COUNT<=PERIOD.
    - One-shot: en<=0, COUNT<=0.
  - Expiry therefore occurs at edge k+P after enable at edge k, then every P cycles in periodic mode.
- PERIOD=0: the channel never expires. COUNT stays 0; if enabled with PERIOD=0, COUNT=0 and holds.
- PERIOD write while running: COUNT is undisturbed; the new value applies at the next reload.
- Simultaneous expire and STATUS clear on the same channel/edge: set wins, pending stays 1.
- Simultaneous CTRL write and expire on the same channel: the CTRL write wins for en/oneshot/irq_en; pending is still set.
- interruptions[IRQ_BASE+i] = pending[i] & irq_en[i].
  - Driven directly from registers, so it is visible in the cycle after the expiry edge.
  - Bits outside the channel range are 0.
- pending is sticky: it remains 1 until cleared via STATUS or reset, independent of en and irq_en.
- COUNT wraps never: decrement stops at the reload point. All arithmetic is unsigned, CNT_WIDTH bits.
- Reset asserted mid-count: all channels return to the reset state asynchronously, and interruptions drops immediately.

Test Plan:
1. Ch0 periodic:
   - Stimulus: write PERIOD=5, then CTRL=0b101 at edge k.
   - Required: COUNT reads 5,4,3,2,1; pending and interruptions[0] rise after edge k+5; COUNT=5 again.
   - After a STATUS write of 1, the line drops; it re-asserts after edge k+10.
2. Ch1 one-shot:
   - Stimulus: PERIOD=3, CTRL=0b111 at edge k.
   - Required: a single expiry at k+3; CTRL.en reads 0; COUNT=0; no further expiry over 20 cycles.
3. Set-wins collision:
   - Stimulus: ch0 PERIOD=2 periodic, with a STATUS clear issued on the same edge as expiry.
   - Required: pending=1 afterwards and interruptions[0] stays high.
4. Mask and mapping with IRQ_BASE=2:
   - Stimulus: ch0 P=4 with irq_en=0; ch1 P=6 with irq_en=1.
   - Required: interruptions[2]=0 while STATUS.pending(ch0)=1; interruptions[3]=1 after 6 cycles; all other bits 0.
5. Mid-run updates:
   - Stimulus: write PERIOD=2 while ch0 (P=8) has COUNT=5; also write ch_sel=6 with NUM_CH=4.
   - Required: the first expiry still comes 5 cycles later, then every 2 cycles; the ch_sel=6 write is ignored and its read returns 0.
6. Reset mid-operation:
   - Stimulus: pulse reset for 10 ns while ch0 COUNT=3 with pending=1.
   - Required: all registers read 0, interruptions=0 asynchronously, and no expiry afterwards until re-enabled.
